bfly_pair_stage: RTL and testbench

BFLY_PAIR_STAGE -- requirements
Module: bfly_pair_stage

---
 rtl/bfly_pair_stage.sv | 94 +++++++++
 tb/tb_bfly_pair_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bfly_pair_stage.sv
// bfly_pair_stage: two-stage radix-2 butterfly pair with a -j twiddle on odd samples
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      first sample of a frame (only counts when in_valid=1)
//   in_valid   in_data carries a sample
//   in_data    4 complex lanes; lane k at [2W*k +: 2W], imag upper W, real lower W
//   out_valid  out_data carries a result (in_valid delayed 2)
//   out_start  out_data carries the first result of a frame
//   out_data   4 complex lanes: L0+L1, L0-L1, L2+L3, (L2-L3)*T
//   ovf        sticky saturation flag, cleared at each out_start
// Build option: define BFLY_SCALE_EN to halve (round half up) before saturation.
module bfly_pair_stage #(
    parameter int W         = 16,
    parameter int FRAME_LEN = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           in_valid,
    input  logic [8*W-1:0] in_data,
    output logic           out_valid,
    output logic           out_start,
    output logic [8*W-1:0] out_data,
    output logic           ovf
);
    localparam int IW = $clog2(FRAME_LEN);

    logic [IW-1:0]   idx, cur_idx;
    logic signed [W:0] a [8];
    logic signed [W:0] p [8];
    logic signed [W:0] q [8];
    logic [8*W-1:0]  rd;
    logic [7:0]      sat;
    logic            v1, s1, rot;

    // Returns {saturated, value}; the top three bits of y must agree for y to fit in W bits.
    function automatic logic [W:0] reduce(input logic signed [W:0] x);
        logic signed [W+1:0] y;
        y = {x[W], x};
`ifdef BFLY_SCALE_EN
        y = (y + $signed((W+2)'(1))) >>> 1;
`endif
        reduce = (y[W+1:W-1] == {3{y[W+1]}}) ? {1'b0, y[W-1:0]}
                                              : {1'b1, y[W+1], {(W-1){~y[W+1]}}};
    endfunction

    // Component c is lane c/2, real when c is even; sign-extended to W+1 bits.
    genvar c;
    generate
        for (c = 0; c < 8; c++) begin : g_comp
            assign a[c] = {in_data[W*c+W-1], in_data[W*c +: W]};
            assign {sat[c], rd[W*c +: W]} = reduce(q[c]);
        end
    endgenerate

    assign cur_idx = (start && in_valid) ? '0 : idx;
    assign rot     = cur_idx[0];

    assign p[0] = a[0] + a[2];
    assign p[1] = a[1] + a[3];
    assign p[2] = a[0] - a[2];
    assign p[3] = a[1] - a[3];
    assign p[4] = a[4] + a[6];
    assign p[5] = a[5] + a[7];
    // (re + j im) * -j = im - j re
    assign p[6] = rot ? a[5] - a[7] : a[4] - a[6];
    assign p[7] = rot ? a[6] - a[4] : a[5] - a[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            v1        <= 1'b0;
            s1        <= 1'b0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
            for (int i = 0; i < 8; i++) q[i] <= '0;
        end else begin
            v1        <= in_valid;
            s1        <= start && in_valid;
            out_valid <= v1;
            out_start <= s1;
            if (in_valid) begin
                idx <= cur_idx + IW'(1);
                for (int i = 0; i < 8; i++) q[i] <= p[i];
            end
            if (v1) begin
                out_data <= rd;
                ovf      <= (s1 ? 1'b0 : ovf) | (|sat);
            end
        end
    end
endmodule

// File: tb/tb_bfly_pair_stage.sv
// tb_bfly_pair_stage: directed self-checking bench for bfly_pair_stage (W=16, FRAME_LEN=2)
module tb_bfly_pair_stage;
`ifdef BFLY_SCALE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif
    localparam logic [6:0] HS_V  = 7'b0011001;
    localparam logic [6:0] HS_ST = 7'b0000011;

    logic         clk, reset_n, start, in_valid;
    logic [127:0] in_data, out_data;
    logic         out_valid, out_start, ovf;
    logic [127:0] junk, dv, e0, e1;
    int           n_chk = 0;
    int           n_err = 0;

    bfly_pair_stage #(.W(16), .FRAME_LEN(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_start(out_start),
        .out_data(out_data), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pk(input logic [15:0] c0, c1, c2, c3, c4, c5, c6, c7);
        pk = {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic st, input logic v, input logic [127:0] d);
        start    = st;
        in_valid = v;
        in_data  = d;
        step;
    endtask

    task automatic xact(input string tag, input logic st, input logic [127:0] d,
                        input logic [127:0] exp, input logic es, input logic eo);
        send(st, 1'b1, d);
        check({tag, "_lat"}, 128'(out_valid), 128'(0));
        send(1'b0, 1'b0, junk);
        check({tag, "_v"}, 128'(out_valid), 128'(1));
        check({tag, "_st"}, 128'(out_start), 128'(es));
        check({tag, "_d"}, out_data, exp);
        check({tag, "_ovf"}, 128'(ovf), 128'(eo));
    endtask

    initial begin
        junk     = {4{32'hA5C3_5A3C}};
        dv       = pk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0020, 16'h0, 16'h0);
        e0       = SC ? pk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0008, 16'h0010, 16'h0008, 16'h0010)
                      : pk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0020, 16'h0010, 16'h0020);
        e1       = SC ? pk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0008, 16'h0010, 16'h0010, 16'hFFF8)
                      : pk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0020, 16'h0020, 16'hFFF0);
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        step;
        step;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_start", 128'(out_start), 128'(0));
        check("rst_data", out_data, 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        reset_n = 1'b1;

        xact("t1", 1'b1, pk(16'h0064, 16'h0014, 16'h0032, 16'hFFF6, 16'h0, 16'h0, 16'h0, 16'h0),
             SC ? pk(16'h004B, 16'h0005, 16'h0019, 16'h000F, 16'h0, 16'h0, 16'h0, 16'h0)
                : pk(16'h0096, 16'h000A, 16'h0032, 16'h001E, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);
        send(1'b0, 1'b0, junk);
        check("hold_v", 128'(out_valid), 128'(0));
        check("hold_d", out_data,
              SC ? pk(16'h004B, 16'h0005, 16'h0019, 16'h000F, 16'h0, 16'h0, 16'h0, 16'h0)
                 : pk(16'h0096, 16'h000A, 16'h0032, 16'h001E, 16'h0, 16'h0, 16'h0, 16'h0));

        xact("t2_rot", 1'b0, dv, e1, 1'b0, 1'b0);
        xact("t3_sat", 1'b0, pk(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
             pk(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0, !SC);
        xact("t4_edge", 1'b0, pk(16'h8000, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h8000),
             SC ? pk(16'h0, 16'h0, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0)
                : pk(16'hFFFF, 16'h0, 16'h8000, 16'h0, 16'h0, 16'hFFFF, 16'h7FFF, 16'h0), 1'b0, 1'b1);
        xact("t4b_sticky", 1'b0, pk(16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
             SC ? pk(16'h1, 16'h1, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0)
                : pk(16'h1, 16'h2, 16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0, 1'b1);
        xact("t5_clr", 1'b1, pk(16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
             SC ? pk(16'h1, 16'h1, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0)
                : pk(16'h1, 16'h2, 16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);
        xact("t6_clrsat", 1'b1, pk(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
             pk(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1, !SC);
        xact("t7_scale", 1'b1, pk(16'h3, 16'h0, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
             SC ? pk(16'h3, 16'h0, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0)
                : pk(16'h5, 16'h0, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            send(HS_ST[i], HS_V[i], HS_V[i] ? dv : junk);
            if (i > 0) begin
                check("hs_valid", 128'(out_valid), 128'(HS_V[i-1]));
                check("hs_start", 128'(out_start), 128'(i == 1));
            end
            if (i == 3 || i == 5) check("hs_d_idx0", out_data, e0);
            if (i == 4) check("hs_d_idx1", out_data, e1);
        end

        send(1'b1, 1'b1, pk(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
        in_data = dv;
        start   = 1'b0;
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_valid", 128'(out_valid), 128'(0));
        check("arst_data", out_data, 128'(0));
        check("arst_ovf", 128'(ovf), 128'(0));
        step;
        reset_n = 1'b1;
        step;
        check("arst_flush1", 128'(out_valid), 128'(0));
        step;
        check("arst_flush2", 128'(out_valid), 128'(0));
        check("arst_ovf2", 128'(ovf), 128'(0));
        xact("rst_next", 1'b0, dv, e0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
